// File: rtl/maze_walker_if.sv
// Request, map-ROM and status signals between the maze walker and its surroundings.
// The walker uses the master view and the host/ROM/display side uses the slave view.
interface maze_walker_if;
  logic       restart;
  logic       dir_valid;
  logic [1:0] dir;
  logic       rom_en;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic       busy;
  logic       moved;
  logic       bump;
  logic       goal;
  logic [7:0] move_count;

  modport master (
    input  restart, dir_valid, dir, rom_data,
    output rom_en, rom_addr, pos_x, pos_y, busy, moved, bump, goal, move_count
  );

  modport slave (
    output restart, dir_valid, dir, rom_data,
    input  rom_en, rom_addr, pos_x, pos_y, busy, moved, bump, goal, move_count
  );
endinterface

// File: rtl/maze_walker.sv
// Player-position controller for an 8x8 maze. It checks the target cell against the
// registered map ROM row and moves only into open cells.
module maze_walker #(
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0,
  parameter int unsigned GOAL_X  = 7,
  parameter int unsigned GOAL_Y  = 7
) (
  input logic          clk,
  input logic          reset,
  maze_walker_if.master bus
);

  localparam logic [2:0] StartX = 3'(START_X);
  localparam logic [2:0] StartY = 3'(START_Y);
  localparam logic [2:0] GoalX  = 3'(GOAL_X);
  localparam logic [2:0] GoalY  = 3'(GOAL_Y);

  typedef enum logic [1:0] {StIdle, StFetch, StCheck} state_e;

  state_e     state_q;
  logic [2:0] pos_x_q, pos_y_q;
  logic [2:0] tx_q, ty_q;
  logic       rom_en_q;
  logic [2:0] rom_addr_q;
  logic       busy_q, moved_q, bump_q, goal_q;
  logic [7:0] count_q;

  // One spare bit so a step off either edge shows up as bit 3 set (-1 wraps to 4'hF).
  logic [3:0] tgt_x, tgt_y;
  logic       tgt_ok;

  always_comb begin
    tgt_x = {1'b0, pos_x_q};
    tgt_y = {1'b0, pos_y_q};
    case (bus.dir)
      2'b00:   tgt_y = {1'b0, pos_y_q} - 4'd1;
      2'b01:   tgt_y = {1'b0, pos_y_q} + 4'd1;
      2'b10:   tgt_x = {1'b0, pos_x_q} - 4'd1;
      default: tgt_x = {1'b0, pos_x_q} + 4'd1;
    endcase
    tgt_ok = !tgt_x[3] && !tgt_y[3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pos_x_q    <= StartX;
      pos_y_q    <= StartY;
      tx_q       <= 3'd0;
      ty_q       <= 3'd0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= 3'd0;
      busy_q     <= 1'b0;
      moved_q    <= 1'b0;
      bump_q     <= 1'b0;
      goal_q     <= 1'b0;
      count_q    <= 8'd0;
    end else if (bus.restart) begin
      // Aborts any in-flight request without a pulse.
      state_q  <= StIdle;
      pos_x_q  <= StartX;
      pos_y_q  <= StartY;
      rom_en_q <= 1'b0;
      busy_q   <= 1'b0;
      moved_q  <= 1'b0;
      bump_q   <= 1'b0;
      goal_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      moved_q <= 1'b0;
      bump_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.dir_valid && !goal_q) begin
            if (tgt_ok) begin
              tx_q       <= tgt_x[2:0];
              ty_q       <= tgt_y[2:0];
              rom_addr_q <= tgt_y[2:0];
              rom_en_q   <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= StFetch;
            end else begin
              bump_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          rom_en_q <= 1'b0;
          state_q  <= StCheck;
        end
        StCheck: begin
          if (bus.rom_data[tx_q]) begin
            pos_x_q <= tx_q;
            pos_y_q <= ty_q;
            moved_q <= 1'b1;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            if (tx_q == GoalX && ty_q == GoalY) goal_q <= 1'b1;
          end else begin
            bump_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          rom_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign bus.rom_en     = rom_en_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.busy       = busy_q;
  assign bus.moved      = moved_q;
  assign bus.bump       = bump_q;
  assign bus.goal       = goal_q;
  assign bus.move_count = count_q;

endmodule

// File: tb/tb_maze_walker.sv
// Scoreboard bench for maze_walker: a grid-level player model predicts every pulse,
// ROM fetch and busy window; a monitor compares them against the DUT each cycle.
module tb_maze_walker;

  localparam int Sx = 0;
  localparam int Sy = 0;
  localparam int Gx = 7;
  localparam int Gy = 7;

  logic clk = 1'b0;
  logic reset;
  maze_walker_if bus();

  maze_walker #(.START_X(Sx), .START_Y(Sy), .GOAL_X(Gx), .GOAL_Y(Gy)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Map ROM: synchronous read with enable.
  logic [7:0] map [8];
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= map[bus.rom_addr];

  typedef struct {
    int cyc;
    bit mv;
    int x;
    int y;
    int cnt;
    bit gl;
  } exp_t;
  typedef struct {
    int cyc;
    int addr;
  } rom_t;

  exp_t exp_q[$];
  rom_t rom_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_x, m_y, m_cnt, m_free;
  bit m_goal;
  int b_lo = -1;
  int b_hi = -2;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_x = Sx; m_y = Sy; m_cnt = 0; m_goal = 0;
  endfunction

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    rom_t r;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        chk("busy", int'(bus.busy), int'(cyc >= b_lo && cyc <= b_hi));
        if (bus.moved && bus.bump) chk("moved_bump_exclusive", 1, 0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("missing_pulse_at_cycle", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        while (rom_q.size() > 0 && rom_q[0].cyc < cyc) begin
          chk("missing_rom_en_at_cycle", cyc, rom_q[0].cyc);
          void'(rom_q.pop_front());
        end
        if (bus.moved || bus.bump) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_is_moved", int'(bus.moved), int'(e.mv));
            chk("pos_x", int'(bus.pos_x), e.x);
            chk("pos_y", int'(bus.pos_y), e.y);
            chk("move_count", int'(bus.move_count), e.cnt);
            chk("goal", int'(bus.goal), int'(e.gl));
          end
        end
        if (bus.rom_en) begin
          if (rom_q.size() == 0) begin
            chk("unexpected_rom_en", 1, 0);
          end else begin
            r = rom_q.pop_front();
            chk("rom_en_cycle", cyc, r.cyc);
            chk("rom_addr", int'(bus.rom_addr), r.addr);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    while (cyc + 1 < m_free) @(negedge clk);
  endtask

  // Issue one request when the model says the walker is idle; predicts the outcome.
  task automatic issue(input logic [1:0] d);
    int c, tx, ty;
    bit open;
    wait_idle();
    c  = cyc;
    tx = m_x;
    ty = m_y;
    case (d)
      2'b00: ty = ty - 1;
      2'b01: ty = ty + 1;
      2'b10: tx = tx - 1;
      default: tx = tx + 1;
    endcase
    bus.dir_valid = 1'b1;
    bus.dir       = d;
    if (!m_goal) begin
      if (tx < 0 || tx > 7 || ty < 0 || ty > 7) begin
        exp_q.push_back('{cyc: c + 1, mv: 1'b0, x: m_x, y: m_y, cnt: m_cnt, gl: m_goal});
        m_free = c + 2;
      end else begin
        rom_q.push_back('{cyc: c + 1, addr: ty});
        b_lo = c + 1;
        b_hi = c + 2;
        open = map[ty][tx];
        if (open) begin
          m_x = tx;
          m_y = ty;
          if (m_cnt < 255) m_cnt++;
          if (tx == Gx && ty == Gy) m_goal = 1'b1;
        end
        exp_q.push_back('{cyc: c + 3, mv: open, x: m_x, y: m_y, cnt: m_cnt, gl: m_goal});
        m_free = c + 4;
      end
    end
    @(negedge clk);
    bus.dir_valid = 1'b0;
  endtask

  // A request strobe while busy; the walker must drop it.
  task automatic drop_pulse(input logic [1:0] d);
    bus.dir_valid = 1'b1;
    bus.dir       = d;
    @(negedge clk);
    bus.dir_valid = 1'b0;
  endtask

  task automatic do_restart();
    int c;
    c = cyc;
    bus.restart = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= c + 1) void'(exp_q.pop_back());
    while (rom_q.size() > 0 && rom_q[$].cyc >= c + 1) void'(rom_q.pop_back());
    if (b_hi >= c + 1) b_hi = c;
    model_reset();
    m_free = c + 2;
    @(negedge clk);
    bus.restart = 1'b0;
    chk("restart_pos_x", int'(bus.pos_x), Sx);
    chk("restart_pos_y", int'(bus.pos_y), Sy);
    chk("restart_count", int'(bus.move_count), 0);
    chk("restart_goal", int'(bus.goal), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pos_x"}, int'(bus.pos_x), Sx);
    chk({tag, "_pos_y"}, int'(bus.pos_y), Sy);
    chk({tag, "_rom_en"}, int'(bus.rom_en), 0);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_moved"}, int'(bus.moved), 0);
    chk({tag, "_bump"}, int'(bus.bump), 0);
    chk({tag, "_goal"}, int'(bus.goal), 0);
    chk({tag, "_count"}, int'(bus.move_count), 0);
  endtask

  task automatic fill_map(input logic [7:0] v);
    for (int i = 0; i < 8; i++) map[i] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.restart   = 1'b0;
    bus.dir_valid = 1'b0;
    bus.dir       = 2'b00;
    reset         = 1'b1;
    fill_map(8'h00);
    model_reset();
    m_free = 0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_values("reset");
    reset  = 1'b0;
    m_free = cyc + 1;

    // Right into an open cell of row 0.
    map[0] = 8'b0000_1111;
    issue(2'b11);
    wait_idle();

    // Down into a wall, then left off the edge.
    do_restart();
    map[1] = 8'b1111_1100;
    issue(2'b01);
    issue(2'b10);
    wait_idle();

    // Strobes during FETCH and CHECK are dropped.
    fill_map(8'hFF);
    issue(2'b11);
    drop_pulse(2'b01);
    drop_pulse(2'b10);
    issue(2'b01);
    drop_pulse(2'b11);
    wait_idle();

    // Walk to the goal, then further requests are ignored.
    do_restart();
    repeat (7) issue(2'b11);
    repeat (7) issue(2'b01);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("goal_reached", int'(bus.goal), 1);
    issue(2'b00);
    repeat (4) @(negedge clk);
    chk("goal_held", int'(bus.goal), 1);
    do_restart();

    // Count saturation.
    for (int i = 0; i < 260; i++) issue(i[0] ? 2'b10 : 2'b11);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("count_saturated", int'(bus.move_count), 255);

    // Reset asserted while in CHECK.
    do_restart();
    issue(2'b11);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_values("reset_in_check");
    exp_q.delete();
    rom_q.delete();
    b_hi = -2;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_free = cyc + 1;

    // Randomized walks on random maps.
    for (int i = 0; i < 500; i++) begin
      int act;
      act = int'($urandom_range(0, 99));
      if (act < 8) begin
        wait_idle();
        for (int r = 0; r < 8; r++) map[r] = 8'($urandom) | 8'($urandom);
      end else if (act < 12) begin
        do_restart();
      end else begin
        issue(2'($urandom));
        if (cyc + 1 < m_free && $urandom_range(0, 2) == 0) drop_pulse(2'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    wait_idle();
    repeat (6) @(negedge clk);
    chk("pulses_outstanding", exp_q.size(), 0);
    chk("rom_fetches_outstanding", rom_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
Name: maze_walker

Overview:
- Player-position controller sitting directly downstream of the maze map ROM (8x8 map, one byte per row, synchronous read with enable, 1 = open cell).
- Accepts direction requests and computes the target cell. Fetches the target row from the ROM and moves only if that cell is open.
- Publishes position, move count and goal status to the display/scoring logic.

Parameters:
- START_X, 0, reset/restart column (0-7)
- START_Y, 0, reset/restart row (0-7)
- GOAL_X, 7, goal column
- GOAL_Y, 7, goal row

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- restart  in  1  synchronous; return to start, clear count/goal
- dir_valid  in  1  one-cycle move request strobe
- dir  in  2  direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- rom_en  out  1  map ROM read enable
- rom_addr  out  3  map ROM row address (target y)
- rom_data  in  8  map ROM row data; bit x = column x, 1 = open
- pos_x  out  3  current column
- pos_y  out  3  current row
- busy  out  1  high while a request is in flight (FETCH or CHECK)
- moved  out  1  one-cycle pulse: move accepted
- bump  out  1  one-cycle pulse: move rejected (wall or edge)
- goal  out  1  sticky; high once pos equals (GOAL_X, GOAL_Y)
- move_count  out  8  accepted moves, saturates at 255

Behaviour:

Reset (async, reset=1):
- pos=(START_X,START_Y); state IDLE.
- rom_en=0, rom_addr=0, busy=0, moved=0, bump=0, goal=0, move_count=0.

State machine:
- States: IDLE, FETCH, CHECK.
- IDLE:
  - dir_valid=1 and goal=0: compute target (tx,ty).
  - Target outside 0..7 (up at y=0, down at y=7, left at x=0, right at x=7): bump=1 for the next cycle, stay IDLE, rom_en stays 0.
  - Target in range: latch tx,ty; rom_addr<=ty; rom_en<=1; go FETCH.
  - dir_valid ignored while goal=1.
- FETCH:
  - rom_en=1 for exactly this one cycle; the ROM registers the row at the end of it.
  - Next state CHECK; rom_en<=0.
- CHECK:
  - Sample rom_data[tx].
  - 1: pos<=(tx,ty), moved pulse next cycle, move_count+1 (hold at 255).
  - 0: bump pulse next cycle, pos unchanged.
  - Always return to IDLE.
- busy=1 in FETCH and CHECK. dir_valid while busy is dropped, not queued.

Latency:
- Request sampled at edge N.
- FETCH during cycle N..N+1; CHECK during cycle N+1..N+2.
- New pos, moved/bump and count visible after edge N+2.
- The next request is accepted at edge N+3 at the earliest.

Goal:
- goal<=1 at the same edge pos is updated to (GOAL_X,GOAL_Y).
- Cleared only by reset or restart.

restart:
- Highest priority after reset; synchronous.
- Any state -> IDLE; pos=start; move_count=0; goal=0; rom_en=0; moved/bump=0.
- An in-flight request is aborted with no pulse.

Outputs:
- moved and bump are never high together.
- Each is high for exactly one cycle per request.

Widths:
- Target arithmetic done in 4 bits to detect the edge case.
- pos stays 3 bits and never wraps.

Test Plan:
- Reset with 8'b00001111 at row 0, dir=11 (right) from (0,0) -> rom_en one cycle with rom_addr=0; after 3 cycles pos=(1,0), moved pulse, move_count=1.
- From (0,0), dir=01 (down), row 1 = 8'b11111100 -> rom_addr=1, bit0=0 -> bump pulse, pos stays (0,0), count 0.
- From (0,0), dir=10 (left) -> bump pulse next cycle, rom_en never asserted, busy stays 0.
- dir_valid pulsed in FETCH and in CHECK -> both ignored; exactly one moved/bump per accepted request.
- Drive a legal path with a ROM model to (7,7) -> goal=1 on arrival; a further dir_valid gives no rom_en and no pulse. restart -> pos=(0,0), goal=0, count=0.
- 256 accepted back-and-forth moves -> move_count saturates at 255. Assert reset in CHECK -> all outputs at reset values immediately, no pulse afterwards.
